// File: rtl/anim_seq_ctrl_if.sv
// Signal bundle between anim_seq_ctrl and the keyboard decoder, video timing and animation FSM.
interface anim_seq_ctrl_if #(
   parameter int DEPTH = 4
);
   logic                    VSync_tick;
   logic                    J_Raw;
   logic                    K_Raw;
   logic                    Beat_Window;
   logic                    Anim_Busy;
   logic                    Anim_Clk_En;
   logic                    J_Press;
   logic                    K_Press;
   logic                    PunchEN;
   logic [$clog2(DEPTH):0]  Queue_Count;
   logic                    Drop;
   logic                    Err;

   modport slave (
      input  VSync_tick, J_Raw, K_Raw, Beat_Window, Anim_Busy,
      output Anim_Clk_En, J_Press, K_Press, PunchEN, Queue_Count, Drop, Err
   );

   modport master (
      output VSync_tick, J_Raw, K_Raw, Beat_Window, Anim_Busy,
      input  Anim_Clk_En, J_Press, K_Press, PunchEN, Queue_Count, Drop, Err
   );
endinterface

// File: rtl/anim_seq_ctrl.sv
// Queues J/K key edges and replays them one at a time as press levels while the animation FSM is idle.
// ANIM_SEQ_BEAT_GATE_EN stores the on-beat bit per J event and drives PunchEN; otherwise PunchEN is 0.
module anim_seq_ctrl #(
   parameter int FRAME_DIV = 4,
   parameter int DEPTH     = 4,
   parameter int GAP_TICKS = 1,
   parameter int TIMEOUT   = 8
) (
   input  logic           Clk,
   input  logic           Reset,
   anim_seq_ctrl_if.slave bus
);

   localparam int AW       = $clog2(DEPTH);
   localparam int CW       = AW + 1;
   localparam int DW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int TW       = $clog2(TIMEOUT + 1);
   localparam int GW       = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
   localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
`ifdef ANIM_SEQ_BEAT_GATE_EN
   localparam int EW = 2;
`else
   localparam int EW = 1;
`endif

   localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_END  = GW'(GAP_LAST);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_ACTIVE,
      S_GAP
   } state_t;

   state_t          state_q, state_d;
   logic            j_prev_q, k_prev_q;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic [EW-1:0]   cmd_q;
   logic [DW-1:0]   div_q;
   logic            clk_en_q;
   logic [TW-1:0]   to_cnt_q, to_cnt_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   logic            drop_q, drop_d;
   logic            err_q, err_d;

   logic            j_rise, k_rise, push_req, push, pop;
   logic            fifo_full, fifo_empty;
   logic [EW-1:0]   push_dat;

   // Entry bit 0 marks a K command; K wins when both keys rise together.
   assign j_rise   = bus.J_Raw & ~j_prev_q;
   assign k_rise   = bus.K_Raw & ~k_prev_q;
   assign push_req = j_rise | k_rise;

   always_comb begin
      push_dat    = '0;
      push_dat[0] = k_rise;
`ifdef ANIM_SEQ_BEAT_GATE_EN
      push_dat[1] = ~k_rise & bus.Beat_Window;
`endif
   end

`ifndef ANIM_SEQ_BEAT_GATE_EN
   logic unused_beat;
   assign unused_beat = bus.Beat_Window;
`endif

   assign fifo_full  = (count_q == FULL_CNT);
   assign fifo_empty = (count_q == '0);
   assign pop        = (state_q == S_IDLE) && !fifo_empty;
   assign push       = push_req && (!fifo_full || pop);
   assign drop_d     = push_req && fifo_full && !pop;

   always_ff @(posedge Clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_dat;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         j_prev_q <= 1'b0;
         k_prev_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cmd_q    <= '0;
         drop_q   <= 1'b0;
      end else begin
         j_prev_q <= bus.J_Raw;
         k_prev_q <= bus.K_Raw;
         drop_q   <= drop_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            cmd_q    <= mem_q[rd_ptr_q];
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // Frame-advance divider: one enable per FRAME_DIV video frames.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         div_q    <= '0;
         clk_en_q <= 1'b0;
      end else begin
         clk_en_q <= 1'b0;
         if (bus.VSync_tick) begin
            if (div_q == DIV_LAST) begin
               div_q    <= '0;
               clk_en_q <= 1'b1;
            end else begin
               div_q <= div_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         to_cnt_q  <= '0;
         gap_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         to_cnt_q  <= to_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      to_cnt_d  = to_cnt_q;
      gap_cnt_d = gap_cnt_q;
      err_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d  = S_ISSUE;
               to_cnt_d = '0;
            end
         end
         S_ISSUE: begin
            if (bus.Anim_Busy) begin
               state_d = S_ACTIVE;
            end else if (clk_en_q) begin
               if (to_cnt_q == TO_LAST) begin
                  // FSM never picked the command up; abandon it and move on.
                  state_d   = S_GAP;
                  gap_cnt_d = '0;
                  err_d     = 1'b1;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
               end
            end
         end
         S_ACTIVE: begin
            if (!bus.Anim_Busy) begin
               state_d   = S_GAP;
               gap_cnt_d = '0;
            end
         end
         S_GAP: begin
            if (GAP_TICKS == 0) begin
               state_d = S_IDLE;
            end else if (clk_en_q) begin
               if (gap_cnt_q == GAP_END) begin
                  state_d = S_IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.Anim_Clk_En = clk_en_q;
   assign bus.K_Press     = (state_q == S_ISSUE) &&  cmd_q[0];
   assign bus.J_Press     = (state_q == S_ISSUE) && !cmd_q[0];
`ifdef ANIM_SEQ_BEAT_GATE_EN
   assign bus.PunchEN     = (state_q == S_ISSUE) && !cmd_q[0] && cmd_q[1];
`else
   assign bus.PunchEN     = 1'b0;
`endif
   assign bus.Queue_Count = count_q;
   assign bus.Drop        = drop_q;
   assign bus.Err         = err_q;

endmodule

// File: tb/tb_anim_seq_ctrl.sv
// Directed bench for anim_seq_ctrl: a cycle table for capture/queueing, then hand sequences for multi-cycle cases.
module tb_anim_seq_ctrl;

   logic Clk = 1'b0;
   logic Reset;
   bit   vs_en = 1'b0;
   int   vs_cnt = 0;
   int   n_checks = 0;
   int   n_fail = 0;

`ifdef ANIM_SEQ_BEAT_GATE_EN
   localparam bit BG = 1'b1;
`else
   localparam bit BG = 1'b0;
`endif

   always #5 Clk = ~Clk;

   anim_seq_ctrl_if #(.DEPTH(4)) bus ();

   anim_seq_ctrl #(
      .FRAME_DIV(4),
      .DEPTH    (4),
      .GAP_TICKS(1),
      .TIMEOUT  (8)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   typedef struct {
      bit       j, k, beat, busy;
      int       qc;
      bit       drop, jp, kp, pe;
   } vec_t;

   function automatic vec_t mk(input bit j, input bit k, input bit b, input bit busy,
                               input int qc, input bit d, input bit jp, input bit kp, input bit pe);
      vec_t v;
      v.j = j; v.k = k; v.beat = b; v.busy = busy;
      v.qc = qc; v.drop = d; v.jp = jp; v.kp = kp; v.pe = pe;
      return v;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return bus.J_Press | bus.K_Press;
         1:       return bus.Anim_Clk_En;
         default: return bus.Err;
      endcase
   endfunction

   task automatic wait_sig(input int which, input int lim, input string name);
      int n = 0;
      while (!sig(which) && n < lim) begin
         tick();
         n++;
      end
      check(name, sig(which), 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_jp"}, bus.J_Press, 0);
      check({tag, "_kp"}, bus.K_Press, 0);
      check({tag, "_pe"}, bus.PunchEN, 0);
      check({tag, "_qc"}, bus.Queue_Count, 0);
      check({tag, "_drop"}, bus.Drop, 0);
      check({tag, "_err"}, bus.Err, 0);
      check({tag, "_clken"}, bus.Anim_Clk_En, 0);
   endtask

   // Frame ticks every 4 cycles while enabled.
   initial begin
      bus.VSync_tick = 1'b0;
      forever begin
         @(posedge Clk);
         #2;
         bus.VSync_tick = vs_en && (vs_cnt == 3);
         vs_cnt = vs_en ? (vs_cnt + 1) % 4 : 0;
      end
   end

   initial begin
      vec_t tbl [14];
      bit   ek  [4];
      bit   epe [4];
      int   kp_cyc, n, n_en, last, first_gap, wide, n_press;
      bit   early, en_prev;

      // Row expectations describe outputs just after the edge that consumes the row's inputs.
      //             j  k  bt bsy qc drp jp kp pe
      tbl[0]  = mk(1, 0, 1, 0,  1, 0,  0, 0, 0);
      tbl[1]  = mk(1, 0, 0, 0,  0, 0,  1, 0, BG);
      tbl[2]  = mk(0, 0, 0, 1,  0, 0,  0, 0, 0);
      tbl[3]  = mk(1, 1, 0, 1,  1, 0,  0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 1,  1, 0,  0, 0, 0);
      tbl[5]  = mk(1, 0, 1, 1,  2, 0,  0, 0, 0);
      tbl[6]  = mk(0, 0, 0, 1,  2, 0,  0, 0, 0);
      tbl[7]  = mk(1, 0, 0, 1,  3, 0,  0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 1,  3, 0,  0, 0, 0);
      tbl[9]  = mk(1, 0, 1, 1,  4, 0,  0, 0, 0);
      tbl[10] = mk(0, 0, 0, 1,  4, 0,  0, 0, 0);
      tbl[11] = mk(1, 0, 1, 1,  4, 1,  0, 0, 0);
      tbl[12] = mk(0, 0, 0, 1,  4, 0,  0, 0, 0);
      tbl[13] = mk(0, 0, 0, 0,  4, 0,  0, 0, 0);

      ek[0] = 1; epe[0] = 0;
      ek[1] = 0; epe[1] = BG;
      ek[2] = 0; epe[2] = 0;
      ek[3] = 0; epe[3] = BG;

      bus.J_Raw = 0; bus.K_Raw = 0; bus.Beat_Window = 0; bus.Anim_Busy = 0;
      Reset = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      Reset = 1'b0;
      tick();

      for (int i = 0; i < 14; i++) begin
         bus.J_Raw = tbl[i].j;
         bus.K_Raw = tbl[i].k;
         bus.Beat_Window = tbl[i].beat;
         bus.Anim_Busy = tbl[i].busy;
         tick();
         check($sformatf("vec%0d_qc", i), bus.Queue_Count, tbl[i].qc);
         check($sformatf("vec%0d_drop", i), bus.Drop, tbl[i].drop);
         check($sformatf("vec%0d_jp", i), bus.J_Press, tbl[i].jp);
         check($sformatf("vec%0d_kp", i), bus.K_Press, tbl[i].kp);
         check($sformatf("vec%0d_pe", i), bus.PunchEN, tbl[i].pe);
      end

      // Drain the four queued commands in order: K, J(beat), J, J(beat).
      vs_en = 1'b1;
      for (int e = 0; e < 4; e++) begin
         wait_sig(0, 100, $sformatf("order%0d_wait", e));
         check($sformatf("order%0d_kp", e), bus.K_Press, ek[e]);
         check($sformatf("order%0d_jp", e), bus.J_Press, !ek[e]);
         check($sformatf("order%0d_pe", e), bus.PunchEN, epe[e]);
         check($sformatf("order%0d_qc", e), bus.Queue_Count, 3 - e);
         bus.Anim_Busy = 1;
         tick();
         check($sformatf("order%0d_release", e), bus.J_Press | bus.K_Press, 0);
         bus.Anim_Busy = 0;
         tick();
      end

      // Single K: busy seen in the second ISSUE cycle gives a two-cycle press.
      bus.K_Raw = 1; tick(); bus.K_Raw = 0;
      wait_sig(0, 100, "k_wait");
      kp_cyc = 1;
      tick();
      kp_cyc += int'(bus.K_Press);
      bus.Anim_Busy = 1;
      tick();
      kp_cyc += int'(bus.K_Press);
      check("k_press_cycles", kp_cyc, 2);
      repeat (30) tick();
      wait_sig(1, 20, "busy_en_wait");
      bus.Anim_Busy = 0;
      tick();
      bus.K_Raw = 1; tick(); bus.K_Raw = 0; tick();
      check("gap_qc", bus.Queue_Count, 1);
      n = 0; early = 0;
      while (!bus.Anim_Clk_En && n < 20) begin
         early |= bus.K_Press;
         tick();
         n++;
      end
      check("gap_en_seen", bus.Anim_Clk_En, 1);
      check("gap_no_early_press", early, 0);
      check("gap_kp_at_en", bus.K_Press, 0);
      tick();
      check("gap_kp_en1", bus.K_Press, 0);
      tick();
      check("gap_kp_en2", bus.K_Press, 1);
      bus.Anim_Busy = 1; tick(); bus.Anim_Busy = 0; tick();

      // Timeout: K never acknowledged, J(beat) queued behind it.
      bus.K_Raw = 1; tick(); bus.K_Raw = 0; tick();
      bus.J_Raw = 1; bus.Beat_Window = 1; tick(); bus.J_Raw = 0; bus.Beat_Window = 0; tick();
      wait_sig(0, 60, "to_wait");
      check("to_first_is_k", bus.K_Press, 1);
      n = 0; n_en = 0; last = -1; first_gap = -1; wide = 0; en_prev = 0;
      while (!bus.Err && n < 300) begin
         if (bus.Anim_Clk_En) begin
            if (bus.K_Press) n_en++;
            if (en_prev) wide++;
            if (last >= 0 && first_gap < 0) first_gap = n - last;
            last = n;
         end
         en_prev = bus.Anim_Clk_En;
         tick();
         n++;
      end
      check("to_err_seen", bus.Err, 1);
      check("to_en_count", n_en, 8);
      check("to_kp_falls", bus.K_Press, 0);
      check("clk_en_period", first_gap, 16);
      check("clk_en_width", wide, 0);
      tick();
      check("err_one_cycle", bus.Err, 0);
      wait_sig(0, 60, "to_next_wait");
      check("to_next_jp", bus.J_Press, 1);
      check("to_next_pe", bus.PunchEN, BG);

      // Reset while issuing with three commands queued.
      repeat (3) begin
         bus.K_Raw = 1; tick(); bus.K_Raw = 0; tick();
      end
      check("pre_rst_qc", bus.Queue_Count, 3);
      check("pre_rst_jp", bus.J_Press, 1);
      Reset = 1'b1;
      tick();
      check_all_zero("midrst");
      Reset = 1'b0;
      n_press = 0;
      repeat (40) begin
         tick();
         n_press += int'(bus.J_Press | bus.K_Press);
      end
      check("post_rst_presses", n_press, 0);
      check("post_rst_qc", bus.Queue_Count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/anim_seq_ctrl.md
# anim_seq_ctrl

Sequencer sitting between the keyboard decoder and the character animation state machine. Edge-detects J/K key events, buffers them in a small FIFO, and replays each as a held press level to the animation FSM only when it is idle. Generates the animation frame-advance enable from the video frame tick and supplies the on-beat punch qualifier. Ensures no keypress is lost while an animation is playing and the FSM never sees overlapping commands.

## Interface
- FRAME_DIV, 4: VSync_tick pulses per Anim_Clk_En pulse (≥1).
- DEPTH, 4: event FIFO depth, power of two, 2..16.
- GAP_TICKS, 1: Anim_Clk_En ticks of forced idle between commands (≥0).
- TIMEOUT, 8: Anim_Clk_En ticks to wait for Anim_Busy before abandoning a command (≥1).
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high; clock Clk.
- VSync_tick  in  1  one-cycle pulse per video frame.
- J_Raw, K_Raw  in  1 each  key levels from the keyboard decoder, synchronous to Clk.
- Beat_Window  in  1  high while the current time is on-beat.
- Anim_Busy  in  1  high while the animation FSM is playing a non-idle animation (not Halted/I_1/Hold).
- Anim_Clk_En  out  1  one-cycle frame-advance enable to the animation FSM.
- J_Press, K_Press  out  1 each  press levels to the animation FSM.
- PunchEN  out  1  on-beat qualifier, valid while J_Press is high.
- Queue_Count  out  $clog2(DEPTH)+1  FIFO occupancy.
- Drop  out  1  one-cycle pulse when an event is discarded (FIFO full).
- Err  out  1  one-cycle pulse when a command times out.

## Operation
- Event capture: rising edge of K_Raw pushes {K, 0}; rising edge of J_Raw pushes {J, on_beat}, where on_beat = Beat_Window in the edge cycle. Simultaneous J and K edges: only K pushed, J silently ignored (matches FSM K priority).
- FIFO: push when not full, else Drop pulses. Push and pop in the same cycle are both honoured, including when full (pop frees the slot).
- States: IDLE, ISSUE, ACTIVE, GAP.
- IDLE: if FIFO non-empty, pop head into the command register this cycle; next state ISSUE, timeout counter cleared.
- ISSUE: K_Press or J_Press = 1 per command type; PunchEN = on_beat for J, 0 for K. Anim_Busy high → ACTIVE. Else each Anim_Clk_En increments the timeout counter; reaching TIMEOUT → GAP, Err pulses.
- ACTIVE: all press outputs 0 (lets the FSM leave Hold). Anim_Busy low → GAP, gap counter cleared.
- GAP: each Anim_Clk_En increments the gap counter; when it equals GAP_TICKS → IDLE. GAP_TICKS = 0: GAP lasts exactly one cycle.
- Divider: counts VSync_tick pulses 0..FRAME_DIV-1; on the pulse at FRAME_DIV-1 the count wraps to 0 and Anim_Clk_En is asserted.

## Timing
- Reset: state IDLE, FIFO empty, all counters 0; every output 0, Queue_Count 0. Reset mid-command drops the press level the following cycle and flushes the FIFO.
- Edge detect: registered previous key level; push occurs in the cycle the edge is seen; Queue_Count reflects it the next cycle.
- Press outputs are decoded from the registered state and command register: high from the first ISSUE cycle, low from the first ACTIVE/GAP cycle.
- IDLE→ISSUE: 1 cycle after FIFO becomes non-empty.
- Anim_Clk_En: registered, high the cycle after the qualifying VSync_tick, exactly 1 cycle wide.
- Drop and Err: registered, 1 cycle wide.

## Configuration
- ANIM_SEQ_BEAT_GATE_EN defined: on_beat stored per J event from Beat_Window; PunchEN driven as above.
- Undefined: on_beat bit not stored (FIFO 1 bit wide), PunchEN tied 0, Beat_Window ignored.

## Test plan
- Single K edge, Anim_Busy raised 2 cycles after K_Press, dropped 30 cycles later, GAP_TICKS=1 → K_Press high exactly 2 cycles, returns to IDLE after one Anim_Clk_En in GAP.
- J edge with Beat_Window=1, macro defined → J_Press=1, PunchEN=1; same with macro undefined → PunchEN=0.
- 5 J edges while Anim_Busy held high, DEPTH=4 → Queue_Count 4, one Drop pulse, remaining 4 commands issued in order.
- J and K rising in the same cycle → one {K} entry, Queue_Count 1, no Drop.
- Anim_Busy never asserted, TIMEOUT=8, FRAME_DIV=4 → Err after 8 Anim_Clk_En pulses (32 VSync_ticks), K_Press falls, next queued command issued.
- Reset while in ISSUE with 3 queued → next cycle all outputs 0, Queue_Count 0, no further presses.
